// File: rtl/usr_piso_tx.sv
// -----------------------------------------------------------------------------
// usr_piso_tx
//   Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted over a
//   valid/ready handshake and shifted out one bit per clock, LSB-first
//   (dir=0, drives the receiver's right-shift serial input) or MSB-first
//   (dir=1, drives the receiver's left-shift serial input). A one-cycle done
//   pulse follows the last bit, and hold freezes the word while it shifts.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset (priority over all inputs)
//   pin         parallel word, sampled only on the load handshake
//   load_valid  pin/dir are valid this cycle
//   load_ready  block can accept a word this cycle (IDLE and not in reset)
//   dir         0 = LSB first, 1 = MSB first; sampled only on handshake
//   hold        freezes shifting while high (honoured in SHIFT only)
//   sout        serial data bit
//   sout_valid  sout carries a valid bit this cycle
//   busy        a word is in flight (state != IDLE)
//   done        one-cycle pulse after the last bit
// -----------------------------------------------------------------------------
module usr_piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             dir,
  input  logic             hold,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dir;
  logic               r_sout;
  logic               r_sout_valid;
  logic               r_done;

  logic               w_load_fire;
  logic               w_last_bit;

  // Bit presented on the wire: the end of the register facing the receiver.
  function automatic logic f_emit_bit(input logic [WIDTH-1:0] shreg,
                                      input logic             msb_first);
    return msb_first ? shreg[WIDTH-1] : shreg[0];
  endfunction

  // Move the register one place toward the emitted end, back-filling with 0.
  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] shreg,
                                               input logic             msb_first);
    return msb_first ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  endfunction

  // Ready is decoded from registered state only; rst masks it so that no
  // word can be accepted while reset is asserted.
  assign load_ready  = (r_state == S_IDLE) && !rst;
  assign busy        = (r_state != S_IDLE);
  assign w_load_fire = load_valid && load_ready;
  assign w_last_bit  = (r_cnt == CNT_LAST);

  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign done       = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_dir        <= 1'b0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_done       <= 1'b0;
          if (w_load_fire) begin
            r_shreg <= pin;
            r_dir   <= dir;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          r_done <= 1'b0;
          // While held, every piece of state (including the bit on the wire)
          // keeps its value, so each hold cycle stretches the word by one.
          if (!hold) begin
            r_sout       <= f_emit_bit(r_shreg, r_dir);
            r_sout_valid <= 1'b1;
            r_shreg      <= f_shift(r_shreg, r_dir);
            r_cnt        <= r_cnt + CNT_ONE;
            if (w_last_bit) begin
              r_state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_done       <= 1'b1;
          r_state      <= S_IDLE;
        end

        default: begin
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_done       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usr_piso_tx.sv
module tb_usr_piso_tx;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] pin;
  logic             load_valid;
  logic             load_ready;
  logic             dir;
  logic             hold;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  usr_piso_tx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pin        (pin),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .dir        (dir),
    .hold       (hold),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance past the next rising edge; sample and drive 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check every output at once: sout, sout_valid, busy, done, load_ready.
  task automatic chk_all(input string tag, input logic e_sout, input logic e_sv,
                         input logic e_busy, input logic e_done, input logic e_lr);
    chk({tag, ".sout"},       sout,       e_sout);
    chk({tag, ".sout_valid"}, sout_valid, e_sv);
    chk({tag, ".busy"},       busy,       e_busy);
    chk({tag, ".done"},       done,       e_done);
    chk({tag, ".load_ready"}, load_ready, e_lr);
  endtask

  // A serial bit in flight: valid, busy, no done, not ready.
  task automatic chk_bit(input string tag, input logic e_sout);
    chk_all(tag, e_sout, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b1;
    pin        = 4'b1111;
    dir        = 1'b0;
    hold       = 1'b0;

    // ---------------- Reset with load_valid asserted ----------------
    tick();
    chk_all("rst_c1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("rst_c2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst        = 1'b0;
    load_valid = 1'b0;
    #1;
    chk_all("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("rst_noacc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // ---------------- LSB first, 1011 -> 1,1,0,1 ----------------
    pin = 4'b1011; dir = 1'b0; load_valid = 1'b1;
    tick();                                   // edge k
    chk_all("lsb_k", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    load_valid = 1'b0; pin = 4'b0000; dir = 1'b1;  // post-handshake changes
    tick(); chk_bit("lsb_b0", 1'b1);
    tick(); chk_bit("lsb_b1", 1'b1);
    tick(); chk_bit("lsb_b2", 1'b0);
    tick(); chk_bit("lsb_b3", 1'b1);
    tick(); chk_all("lsb_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("lsb_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // ---------------- MSB first, 1011 -> 1,0,1,1 ----------------
    pin = 4'b1011; dir = 1'b1; load_valid = 1'b1;
    tick();
    chk_all("msb_k", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    load_valid = 1'b0;
    tick(); chk_bit("msb_b0", 1'b1);
    tick(); chk_bit("msb_b1", 1'b0);
    tick(); chk_bit("msb_b2", 1'b1);
    tick(); chk_bit("msb_b3", 1'b1);
    tick(); chk_all("msb_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("msb_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // ---------------- Hold mid-word, 0110 LSB -> 0,1,(1,1),1,0 ----------------
    pin = 4'b0110; dir = 1'b0; load_valid = 1'b1;
    tick();                                   // edge k
    load_valid = 1'b0;
    tick(); chk_bit("hold_b0", 1'b0);         // k+1
    tick(); chk_bit("hold_b1", 1'b1);         // k+2
    hold = 1'b1;
    tick(); chk_bit("hold_h1", 1'b1);         // k+3 held
    tick(); chk_bit("hold_h2", 1'b1);         // k+4 held
    hold = 1'b0;
    tick(); chk_bit("hold_b2", 1'b1);         // k+5
    tick(); chk_bit("hold_b3", 1'b0);         // k+6
    tick(); chk_all("hold_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  // k+7

    // ---------------- Hold before the first bit ----------------
    tick();
    pin = 4'b0001; dir = 1'b0; load_valid = 1'b1; hold = 1'b1;
    tick();                                   // handshake, held next edge
    load_valid = 1'b0;
    tick(); chk_all("hold0_pre", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    hold = 1'b0;
    tick(); chk_bit("hold0_b0", 1'b1);
    tick(); chk_bit("hold0_b1", 1'b0);
    tick(); chk_bit("hold0_b2", 1'b0);
    tick(); chk_bit("hold0_b3", 1'b0);
    hold = 1'b1;                              // ignored in DONE
    tick(); chk_all("hold0_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    hold = 1'b0;
    tick();

    // ---------------- Busy ignore + back-to-back ----------------
    pin = 4'b1101; dir = 1'b0; load_valid = 1'b1;
    tick();                                   // edge k
    pin = 4'b0000;                            // load_valid stays high: ignored
    tick(); chk_bit("b2b_w1b0", 1'b1);
    tick(); chk_bit("b2b_w1b1", 1'b0);
    tick(); chk_bit("b2b_w1b2", 1'b1);
    tick(); chk_bit("b2b_w1b3", 1'b1);
    pin = 4'b1001; dir = 1'b1;
    tick(); chk_all("b2b_done1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  // k+5
    tick();                                   // k+6: handshake in done cycle
    chk_all("b2b_acc", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    load_valid = 1'b0;
    tick(); chk_bit("b2b_w2b0", 1'b1);        // k+7
    tick(); chk_bit("b2b_w2b1", 1'b0);
    tick(); chk_bit("b2b_w2b2", 1'b0);
    tick(); chk_bit("b2b_w2b3", 1'b1);
    tick(); chk_all("b2b_done2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // ---------------- Reset mid-word ----------------
    pin = 4'b1111; dir = 1'b0; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick(); chk_bit("rmw_b0", 1'b1);
    tick(); chk_bit("rmw_b1", 1'b1);
    rst = 1'b1;
    #1;
    chk("rmw_lr_in_rst", load_ready, 1'b0);
    tick(); chk_all("rmw_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("rmw_lr_rel", load_ready, 1'b1);
    tick(); chk_all("rmw_nodone", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pin = 4'b0001; dir = 1'b0; load_valid = 1'b1;
    tick();
    chk_all("rmw_k", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    load_valid = 1'b0;
    tick(); chk_bit("rmw_w_b0", 1'b1);
    tick(); chk_bit("rmw_w_b1", 1'b0);
    tick(); chk_bit("rmw_w_b2", 1'b0);
    tick(); chk_bit("rmw_w_b3", 1'b0);
    tick(); chk_all("rmw_w_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("rmw_w_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
